// File: rtl/crc16_frame_checker.sv
// CRC-16 frame checker: accumulates an MSB-first CRC over a received frame
// (payload followed by the transmitted CRC, high byte first) and reports
// pass/fail once the frame ends. A correct frame leaves a zero residue.
//
// Handshake: a byte is consumed on every rising edge where byte_valid is high
// and the block is in RECV. There is no back-pressure. load and d_finish are
// single-cycle pulses. done is a one-cycle pulse that qualifies crc_ok/crc_err,
// which then hold until the next load or reset.
module crc16_frame_checker #(
    parameter logic [15:0] POLY    = 16'h1021,
    parameter logic [15:0] INIT    = 16'hFFFF,
    parameter int          MAX_LEN = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    input  logic        d_finish,
    output logic        busy,
    output logic        done,
    output logic        crc_ok,
    output logic        crc_err,
    output logic [7:0]  byte_cnt,
    output logic [15:0] crc_reg
);

    localparam logic [7:0] MAX_CNT = 8'(MAX_LEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic        done_nxt;
    logic        ok_nxt;
    logic        err_nxt;
    logic [7:0]  cnt_nxt;
    logic [15:0] crc_nxt;

    // Eight serial shift-and-reduce steps of one byte, unrolled into one cycle.
    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int i = 0; i < 8; i++) begin
            if (r[15]) r = {r[14:0], 1'b0} ^ POLY;
            else       r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    // State and datapath registers; reset forces the idle values immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            done     <= 1'b0;
            crc_ok   <= 1'b0;
            crc_err  <= 1'b0;
            byte_cnt <= 8'd0;
            crc_reg  <= INIT;
        end else begin
            state    <= state_nxt;
            done     <= done_nxt;
            crc_ok   <= ok_nxt;
            crc_err  <= err_nxt;
            byte_cnt <= cnt_nxt;
            crc_reg  <= crc_nxt;
        end
    end

    // Next-state and next-datapath logic; load restarts a frame from any state.
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        ok_nxt    = crc_ok;
        err_nxt   = crc_err;
        cnt_nxt   = byte_cnt;
        crc_nxt   = crc_reg;
        if (load) begin
            state_nxt = RECV;
            ok_nxt    = 1'b0;
            err_nxt   = 1'b0;
            cnt_nxt   = 8'd0;
            crc_nxt   = INIT;
        end else begin
            case (state)
                RECV: begin
                    if (byte_valid && (byte_cnt == MAX_CNT)) begin
                        // Frame too long: drop the byte and fail right away.
                        err_nxt   = 1'b1;
                        done_nxt  = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        if (byte_valid) begin
                            crc_nxt = crc_byte(crc_reg, byte_in);
                            cnt_nxt = byte_cnt + 8'd1;
                        end
                        if (d_finish) state_nxt = CHECK;
                    end
                end
                CHECK: begin
                    if ((crc_reg == 16'h0000) && (byte_cnt >= 8'd3)) ok_nxt = 1'b1;
                    else                                              err_nxt = 1'b1;
                    done_nxt  = 1'b1;
                    state_nxt = DONE;
                end
                default: begin
                    // IDLE and DONE ignore byte_valid and d_finish.
                    state_nxt = state;
                end
            endcase
        end
    end

    // Busy covers reception and the checking cycle.
    always_comb begin
        busy = (state == RECV) || (state == CHECK);
    end

endmodule

// File: tb/tb_crc16_frame_checker.sv
// Bench for crc16_frame_checker: a default instance (a) and a MAX_LEN=4
// instance (b) share the stimulus; each test task checks its own results.
module tb_crc16_frame_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        load, byte_valid, d_finish;
    logic [7:0]  byte_in;

    logic        busy_a, done_a, crc_ok_a, crc_err_a;
    logic [7:0]  byte_cnt_a;
    logic [15:0] crc_reg_a;
    logic        busy_b, done_b, crc_ok_b, crc_err_b;
    logic [7:0]  byte_cnt_b;
    logic [15:0] crc_reg_b;

    int          n_vec = 0;
    int          n_err = 0;
    logic [9:0]  exp_q[$];          // {crc_ok, crc_err, byte_cnt}
    logic [7:0]  frame_q[$];

    crc16_frame_checker dut_a (
        .clk(clk), .rst(rst), .load(load), .byte_valid(byte_valid),
        .byte_in(byte_in), .d_finish(d_finish), .busy(busy_a), .done(done_a),
        .crc_ok(crc_ok_a), .crc_err(crc_err_a), .byte_cnt(byte_cnt_a), .crc_reg(crc_reg_a)
    );

    crc16_frame_checker #(.MAX_LEN(4)) dut_b (
        .clk(clk), .rst(rst), .load(load), .byte_valid(byte_valid),
        .byte_in(byte_in), .d_finish(d_finish), .busy(busy_b), .done(done_b),
        .crc_ok(crc_ok_b), .crc_err(crc_err_b), .byte_cnt(byte_cnt_b), .crc_reg(crc_reg_b)
    );

    // clock / global time limit
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // crc_ok and crc_err must never be high together
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            n_vec++;
            if ((crc_ok_a & crc_err_a) !== 1'b0) begin
                n_err++;
                $display("FAIL ok_err_exclusive: got ok=%b err=%b, required not both", crc_ok_a, crc_err_a);
            end
        end
    end

    // bit-serial reference CRC (feedback form)
    function automatic logic [15:0] model_crc(input logic [15:0] c, input logic [7:0] b);
        logic fb;
        for (int i = 7; i >= 0; i--) begin
            fb = c[15] ^ b[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    function automatic logic [9:0] result(input bit sel);
        return sel ? {crc_ok_b, crc_err_b, byte_cnt_b} : {crc_ok_a, crc_err_a, byte_cnt_a};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic l, input logic v, input logic [7:0] b, input logic f);
        @(negedge clk);
        load = l; byte_valid = v; byte_in = b; d_finish = f;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ref_frame();
        frame_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h29, 8'hB1};
    endtask

    // load, send frame_q, optionally check crc after the 9th byte, then d_finish
    task automatic send_frame(input bit chk9);
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        foreach (frame_q[i]) begin
            drive(1'b0, 1'b1, frame_q[i], 1'b0);
            if (chk9 && i == 8) begin
                step();
                n_vec++;
                if (crc_reg_a !== 16'h29B1) begin
                    n_err++;
                    $display("FAIL crc_after_9: got %h, required 29b1", crc_reg_a);
                end
            end
        end
        drive(1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    // waits up to 8 edges for done; inputs return to idle after the first edge
    task automatic wait_done(input bit sel, output int edges);
        edges = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            load = 1'b0; byte_valid = 1'b0; d_finish = 1'b0;
            edges++;
            if ((sel ? done_b : done_a) === 1'b1) return;
        end
        edges = -1;
    endtask

    // pop the scoreboard and compare against the selected instance
    task automatic score(input bit sel, input string name);
        logic [9:0] exp, obs;
        exp = exp_q.pop_front();
        obs = result(sel);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got ok=%b err=%b cnt=%0d, required ok=%b err=%b cnt=%0d",
                     name, obs[9], obs[8], obs[7:0], exp[9], exp[8], exp[7:0]);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0; load = 1'b0; byte_valid = 1'b0; byte_in = 8'h00; d_finish = 1'b0;
        repeat (3) step();
        n_vec++;
        if ({busy_a, done_a, crc_ok_a, crc_err_a, byte_cnt_a, crc_reg_a} !== {4'b0000, 8'd0, 16'hFFFF}) begin
            n_err++;
            $display("FAIL reset_values: got busy=%b done=%b ok=%b err=%b cnt=%0d crc=%h, required 0 0 0 0 0 ffff",
                     busy_a, done_a, crc_ok_a, crc_err_a, byte_cnt_a, crc_reg_a);
        end
        @(negedge clk);
        rst = 1'b1;
        // bytes and d_finish without load must be ignored
        drive(1'b0, 1'b1, 8'hAA, 1'b1);
        drive(1'b0, 1'b1, 8'h55, 1'b0);
        step();
        byte_valid = 1'b0; d_finish = 1'b0;
        step();
        n_vec++;
        if ({busy_a, done_a, byte_cnt_a, crc_reg_a} !== {2'b00, 8'd0, 16'hFFFF}) begin
            n_err++;
            $display("FAIL idle_ignore: got busy=%b done=%b cnt=%0d crc=%h, required 0 0 0 ffff",
                     busy_a, done_a, byte_cnt_a, crc_reg_a);
        end
    endtask

    task automatic test_good_frame();
        int e;
        ref_frame();
        send_frame(1'b1);
        exp_q.push_back({1'b1, 1'b0, 8'd11});
        wait_done(1'b0, e);
        n_vec++;
        if (e !== 2) begin
            n_err++;
            $display("FAIL good_latency: got %0d edges, required 2", e);
        end
        score(1'b0, "good_result");
        step();
        n_vec++;
        if ({done_a, busy_a, crc_ok_a} !== 3'b001) begin
            n_err++;
            $display("FAIL good_done_pulse: got done=%b busy=%b ok=%b, required 0 0 1", done_a, busy_a, crc_ok_a);
        end
    endtask

    task automatic test_ignore_in_done();
        drive(1'b0, 1'b1, 8'h12, 1'b1);
        drive(1'b0, 1'b1, 8'h34, 1'b0);
        step();
        byte_valid = 1'b0; d_finish = 1'b0;
        repeat (2) step();
        n_vec++;
        if ({done_a, busy_a, crc_ok_a, crc_err_a, byte_cnt_a} !== {4'b0010, 8'd11}) begin
            n_err++;
            $display("FAIL done_ignore: got done=%b busy=%b ok=%b err=%b cnt=%0d, required 0 0 1 0 11",
                     done_a, busy_a, crc_ok_a, crc_err_a, byte_cnt_a);
        end
    endtask

    task automatic test_corrupt();
        int e;
        ref_frame();
        frame_q[4] = 8'h34;
        send_frame(1'b0);
        exp_q.push_back({1'b0, 1'b1, 8'd11});
        wait_done(1'b0, e);
        n_vec++;
        if (e !== 2) begin
            n_err++;
            $display("FAIL corrupt_latency: got %0d edges, required 2", e);
        end
        score(1'b0, "corrupt_result");
        step();
        n_vec++;
        if (done_a !== 1'b0) begin
            n_err++;
            $display("FAIL corrupt_done_pulse: got done=%b, required 0", done_a);
        end
    endtask

    task automatic test_short();
        int e;
        frame_q = '{8'hFF, 8'hFF};
        send_frame(1'b0);
        exp_q.push_back({1'b0, 1'b1, 8'd2});
        wait_done(1'b0, e);
        n_vec++;
        if (e !== 2) begin
            n_err++;
            $display("FAIL short_latency: got %0d edges, required 2", e);
        end
        score(1'b0, "short_result");
    endtask

    task automatic test_overflow();
        int e;
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 8'(8'h10 + i), 1'b0);
        exp_q.push_back({1'b0, 1'b1, 8'd4});
        wait_done(1'b1, e);
        n_vec++;
        if (e !== 1) begin
            n_err++;
            $display("FAIL overflow_latency: got %0d edges, required 1", e);
        end
        score(1'b1, "overflow_result");
        n_vec++;
        if (busy_b !== 1'b0) begin
            n_err++;
            $display("FAIL overflow_busy: got %b, required 0", busy_b);
        end
    endtask

    task automatic test_abort();
        int e, dones;
        dones = 0;
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 8'(8'hA0 + i), 1'b0);
            step();
            if (done_a === 1'b1) dones++;
        end
        ref_frame();
        send_frame(1'b0);
        exp_q.push_back({1'b1, 1'b0, 8'd11});
        wait_done(1'b0, e);
        if (e > 0) dones++;
        score(1'b0, "abort_result");
        for (int i = 0; i < 3; i++) begin
            step();
            if (done_a === 1'b1) dones++;
        end
        n_vec++;
        if (dones !== 1) begin
            n_err++;
            $display("FAIL abort_single_done: got %0d done pulses, required 1", dones);
        end
    endtask

    task automatic test_load_finish_collide();
        int e, dones;
        dones = 0;
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b1, 8'h11, 1'b0);
        drive(1'b0, 1'b1, 8'h22, 1'b0);
        drive(1'b1, 1'b0, 8'h00, 1'b1);
        step();
        load = 1'b0; d_finish = 1'b0;
        n_vec++;
        if ({busy_a, done_a, byte_cnt_a, crc_reg_a} !== {2'b10, 8'd0, 16'hFFFF}) begin
            n_err++;
            $display("FAIL collide_restart: got busy=%b done=%b cnt=%0d crc=%h, required 1 0 0 ffff",
                     busy_a, done_a, byte_cnt_a, crc_reg_a);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            if (done_a === 1'b1) dones++;
        end
        n_vec++;
        if (dones !== 0 || busy_a !== 1'b1) begin
            n_err++;
            $display("FAIL collide_no_done: got %0d done pulses busy=%b, required 0 and 1", dones, busy_a);
        end
        ref_frame();
        send_frame(1'b0);
        exp_q.push_back({1'b1, 1'b0, 8'd11});
        wait_done(1'b0, e);
        score(1'b0, "collide_result");
    endtask

    task automatic test_async_reset();
        int e;
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
        @(negedge clk);
        byte_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        n_vec++;
        if ({busy_a, done_a, crc_ok_a, crc_err_a, byte_cnt_a, crc_reg_a} !== {4'b0000, 8'd0, 16'hFFFF}) begin
            n_err++;
            $display("FAIL async_reset: got busy=%b done=%b ok=%b err=%b cnt=%0d crc=%h, required 0 0 0 0 0 ffff",
                     busy_a, done_a, crc_ok_a, crc_err_a, byte_cnt_a, crc_reg_a);
        end
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b1, 8'h77, 1'b0);
        step();
        byte_valid = 1'b0;
        n_vec++;
        if ({busy_a, byte_cnt_a} !== {1'b0, 8'd0}) begin
            n_err++;
            $display("FAIL post_reset_idle: got busy=%b cnt=%0d, required 0 0", busy_a, byte_cnt_a);
        end
        ref_frame();
        send_frame(1'b1);
        exp_q.push_back({1'b1, 1'b0, 8'd11});
        wait_done(1'b0, e);
        score(1'b0, "post_reset_result");
    endtask

    task automatic test_random();
        int e, len, pos;
        logic [15:0] c;
        bit corrupt;
        for (int f = 0; f < 6; f++) begin
            len = $urandom_range(1, 20);
            frame_q.delete();
            c = 16'hFFFF;
            for (int i = 0; i < len; i++) begin
                frame_q.push_back(8'($urandom_range(0, 255)));
                c = model_crc(c, frame_q[i]);
            end
            frame_q.push_back(c[15:8]);
            frame_q.push_back(c[7:0]);
            corrupt = ($urandom_range(0, 1) == 1);
            if (corrupt) begin
                pos = $urandom_range(0, len + 1);
                frame_q[pos] = frame_q[pos] ^ (8'h01 << $urandom_range(0, 7));
            end
            send_frame(1'b0);
            exp_q.push_back({~corrupt, corrupt, 8'(len + 2)});
            wait_done(1'b0, e);
            n_vec++;
            if (e !== 2) begin
                n_err++;
                $display("FAIL random_latency: frame %0d got %0d edges, required 2", f, e);
            end
            score(1'b0, "random_result");
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_good_frame();
        test_ignore_in_done();
        test_corrupt();
        test_short();
        test_overflow();
        test_abort();
        test_load_finish_collide();
        test_async_reset();
        test_random();
        n_vec++;
        if (exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/crc16_frame_checker.md
CRC16_FRAME_CHECKER -- requirements
Module: crc16_frame_checker

Interface
REQ-001 SHALL have parameter POLY, default 16'h1021, CRC-16 generator polynomial (MSB-first, non-reflected).
REQ-002 SHALL have parameter INIT, default 16'hFFFF, CRC register value at frame start; no final XOR.
REQ-003 SHALL have parameter MAX_LEN, default 255, maximum frame length in bytes, payload plus 2 CRC bytes.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port load  input  1  one-cycle pulse starting a new frame.
REQ-007 SHALL have port byte_valid  input  1  byte_in carries a frame byte this cycle.
REQ-008 SHALL have port byte_in  input  8  frame byte: payload, then CRC high byte, then CRC low byte.
REQ-009 SHALL have port d_finish  input  1  one-cycle pulse marking end of frame.
REQ-010 SHALL have port busy  output  1  high while a frame is being received or checked.
REQ-011 SHALL have port done  output  1  one-cycle pulse when the check result is valid.
REQ-012 SHALL have port crc_ok  output  1  frame passed; held until next load or reset.
REQ-013 SHALL have port crc_err  output  1  frame failed; held until next load or reset.
REQ-014 SHALL have port byte_cnt  output  8  bytes accepted in the current or last frame.
REQ-015 SHALL have port crc_reg  output  16  running CRC register, for debug.

Function
REQ-016 SHALL implement FSM states IDLE, RECV, CHECK, DONE; reset state IDLE.
REQ-017 SHALL ignore byte_valid and d_finish in IDLE and DONE.
REQ-018 SHALL move IDLE/DONE -> RECV on load: crc_reg<=INIT, byte_cnt<=0, crc_ok<=0, crc_err<=0.
REQ-019 SHALL, in RECV with byte_valid, update crc_reg by 8 MSB-first serial steps of POLY in one cycle and increment byte_cnt.
REQ-020 SHALL, on d_finish in RECV, process a same-cycle byte_valid first, then move to CHECK.
REQ-021 SHALL, in CHECK, set crc_ok=1 iff crc_reg==16'h0000 and byte_cnt>=3; otherwise crc_err=1; pulse done; then go to DONE.
REQ-022 SHALL give latency of exactly 2 rising edges from the edge sampling d_finish to done high; done high for exactly one cycle.
REQ-023 SHALL, when byte_valid arrives with byte_cnt==MAX_LEN, drop the byte, set crc_err=1, pulse done, and go to DONE without waiting for d_finish.
REQ-024 SHALL, on load during RECV, abort the current frame with no done pulse and restart per REQ-018.
REQ-025 SHALL let load take priority when load and d_finish coincide.
REQ-026 SHALL never assert crc_ok and crc_err together.
REQ-027 SHALL drive busy high in RECV and CHECK, low in IDLE and DONE.

Reset
REQ-028 SHALL, on rst low at any time including mid-frame, immediately force state IDLE, busy=0, done=0, crc_ok=0, crc_err=0, byte_cnt=0, crc_reg=INIT.
REQ-029 SHALL leave the block idle after rst deasserts until the first load.

Verification
REQ-030 Good frame: load; bytes 31 32 33 34 35 36 37 38 39 29 B1; d_finish -> done 2 edges later, crc_ok=1, crc_err=0, byte_cnt=11; crc_reg=16'h29B1 after the 9th byte.
REQ-031 Corrupted frame: as REQ-030 with byte 35 changed to 34 -> crc_ok=0, crc_err=1, done pulsed once.
REQ-032 Short frame: load; bytes FF FF; d_finish -> crc_err=1, byte_cnt=2.
REQ-033 Overflow: MAX_LEN=4; load; 5 bytes, no d_finish -> crc_err=1 and done on the 5th byte, byte_cnt=4.
REQ-034 Abort/restart: load, 3 bytes, load, then the REQ-030 frame -> single done, crc_ok=1, byte_cnt=11.
REQ-035 Async reset: rst low mid-frame between clock edges -> all outputs at reset values before the next edge; a later REQ-030 frame passes.
